frame_dma_sched: RTL and testbench
==================================

Name: frame_dma_sched

Overview:
- Schedules the per-frame MM2S DMA fetch that feeds the HDMI output controller's AXI-Stream pixel FIFO.
- Issues one whole-frame command (640x480x3 bytes) from the current front buffer and primes the FIFO once on enable; re-arms on every frame_end from the timing generator.
- Implements CPU-requested double-buffer swaps, applied only at frame boundaries.
- Reports underruns, DMA errors and frame/vsync events to the MicroBlaze.

Parameters:
- ADDR_W, 32, width of buffer base addresses and cmd_addr.
- LEN_W, 23, width of cmd_len (byte count).
- FRAME_BYTES, 921600, bytes per frame (640*480*3). Must be < 2^LEN_W.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  pixel clock (25 MHz); all logic runs in this domain.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run scheduler.
- buf0_addr  in  ADDR_W  base of buffer 0. Sampled at command issue.
- buf1_addr  in  ADDR_W  base of buffer 1. Sampled at command issue.
- swap_req  in  1  single-cycle pulse requesting a front-buffer swap.
- frame_end  in  1  single-cycle pulse from the VGA timing generator.
- cmd_valid  out  1  DMA command valid.
- cmd_ready  in  1  DMA command ready.
- cmd_addr  out  ADDR_W  command start address.
- cmd_len  out  LEN_W  command byte count.
- dma_done  in  1  pulse: current transfer complete (tlast sent).
- dma_err  in  1  pulse: transfer error.
- front_sel  out  1  index of the buffer currently scanned out.
- swap_pending  out  1  swap requested but not yet applied.
- swap_done  out  1  single-cycle pulse when a swap is applied.
- vsync_irq  out  1  single-cycle pulse, one per consumed frame_end.
- underrun  out  1  sticky flag; cleared on the enable 0->1 edge.
- err  out  1  sticky flag; cleared on the enable 0->1 edge.
- frame_cnt  out  CNT_W  completed transfers, wrapping.
- underrun_cnt  out  CNT_W  underrun events, saturating at all-ones.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including cmd_addr, cmd_len, front_sel and both counters.
- States: IDLE, ISSUE, XFER, ARM, ERR.

Transitions:
- IDLE -> ISSUE on enable=1. This is the priming fetch; no frame_end is needed. The enable 0->1 edge also clears underrun, err and both counters.
- ISSUE: cmd_valid=1. cmd_addr = front_sel ? buf1_addr : buf0_addr, cmd_len = FRAME_BYTES, both registered on ISSUE entry and held stable until accepted. On cmd_valid&cmd_ready (same cycle) -> XFER; cmd_valid drops the next cycle. enable=0 never withdraws cmd_valid.
- XFER: on dma_done, frame_cnt+1 (wrap), then -> ARM if enable=1, else -> IDLE.
- ARM: on frame_end -> ISSUE, with vsync_irq pulsed the same cycle. If a swap is pending (including a swap_req in this same cycle), front_sel toggles before the address is registered, swap_done pulses and swap_pending clears. enable=0 in ARM -> IDLE immediately.
- dma_err in XFER -> ERR, err=1. ERR holds cmd_valid=0 and ignores frame_end. Exit ERR -> IDLE when enable=0.

Underrun:
- frame_end in ISSUE or XFER: underrun=1, underrun_cnt+1 (saturating), vsync_irq still pulses.
- No extra command is queued; the next fetch issues on the first frame_end after reaching ARM.
- frame_end in IDLE or ERR is ignored (no irq).

Swap:
- swap_req while pending is idempotent: one toggle per boundary.
- Swaps requested in IDLE are still applied at the next ARM boundary.
- The priming fetch uses the current front_sel without applying the pending swap.

Other rules:
- dma_done and dma_err in the same cycle: error wins (-> ERR, frame_cnt not incremented).
- dma_done or dma_err outside XFER is ignored.
- Latency: frame_end in ARM -> cmd_valid=1 on the next clk edge (1 cycle).

Decomposition:
- Shared package frame_sched_pkg: state encoding (3-bit localparams), FRAME_BYTES and the H/V timing constants (800x525, porches) shared with the VGA timing generator.
- One sub-module, sat_counter (parameter W, ports inc, clr, saturate-enable), instantiated for frame_cnt (wrapping) and underrun_cnt (saturating).

Test Plan:
- Reset release, enable=1, cmd_ready=1, buf0_addr=0x8000_0000 -> cmd_valid for 1 cycle, cmd_addr=0x8000_0000, cmd_len=921600; state XFER.
- dma_done, then frame_end 20 cycles later -> vsync_irq pulse, cmd_valid 1 cycle after, frame_cnt=1, same address.
- swap_req pulsed during XFER, buf1_addr=0x8010_0000 -> swap_pending=1 until next frame_end; then swap_done pulse, front_sel=1, cmd_addr=0x8010_0000.
- frame_end while in XFER (dma_done withheld) -> underrun=1, underrun_cnt=1, no second cmd_valid; after dma_done, next frame_end issues normally.
- cmd_ready held 0 for 5 cycles then enable=0 -> cmd_valid and cmd_addr stay stable until accepted; after dma_done, state=IDLE and outputs quiescent.
- dma_err and dma_done in the same cycle -> err=1, frame_cnt unchanged, frame_end ignored; enable 0 then 1 -> err and counters cleared, priming command reissued.

Source files
------------

// File: rtl/frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sched_pkg
// Description : Shared constants for the HDMI frame path: scheduler state
//               encoding, frame size and 640x480@60 VGA timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sched_pkg;

  // Scheduler state encoding (3-bit)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_XFER  = ST_XFER,
    S_ARM   = ST_ARM,
    S_ERR   = ST_ERR
  } sched_state_t;

  // 640x480 timing shared with the VGA timing generator
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // One full RGB888 frame in bytes
  localparam int FRAME_BYTES = H_ACTIVE * V_ACTIVE * 3;       // 921600

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter with synchronous clear; either wraps or sticks
//               at all-ones depending on sat_en.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         sat_en,
  output logic [W-1:0] q
);

  // Clear beats a same-cycle increment; saturation only blocks the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(sat_en && (&q))) begin
      q <= q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_dma_sched
// Description : Per-frame MM2S DMA command scheduler for the HDMI output.
//               Primes one whole-frame fetch on enable, re-arms on each
//               frame_end, applies double-buffer swaps only at frame
//               boundaries and flags underruns / DMA errors.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_dma_sched #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 23,
  parameter int FRAME_BYTES = frame_sched_pkg::FRAME_BYTES,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] buf0_addr,
  input  logic [ADDR_W-1:0] buf1_addr,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              dma_done,
  input  logic              dma_err,
  output logic              front_sel,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              vsync_irq,
  output logic              underrun,
  output logic              err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  underrun_cnt
);

  import frame_sched_pkg::*;

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         r_enable_d;
  logic         w_en_rise;
  logic         w_issue_load;   // register a new command this cycle
  logic         w_apply_swap;   // toggle front buffer at this boundary
  logic         w_front_nxt;
  logic         w_frame_inc;
  logic         w_underrun_ev;
  logic         w_err_ev;

  assign w_en_rise   = enable & ~r_enable_d;
  assign w_front_nxt = front_sel ^ w_apply_swap;

  // State register plus enable edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_enable_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_enable_d <= enable;
    end
  end

  // Next-state decode and per-cycle event strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_load  = 1'b0;
    w_apply_swap  = 1'b0;
    w_frame_inc   = 1'b0;
    w_underrun_ev = 1'b0;
    w_err_ev      = 1'b0;
    cmd_valid     = 1'b0;
    vsync_irq     = 1'b0;
    swap_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Priming fetch: uses the current front buffer, no boundary needed
        if (enable) begin
          w_state_nxt  = S_ISSUE;
          w_issue_load = 1'b1;
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (frame_end) begin
          w_underrun_ev = 1'b1;
          vsync_irq     = 1'b1;
        end
        if (cmd_ready) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        if (frame_end) begin
          w_underrun_ev = 1'b1;
          vsync_irq     = 1'b1;
        end
        if (dma_err) begin
          w_err_ev    = 1'b1;
          w_state_nxt = S_ERR;
        end else if (dma_done) begin
          w_frame_inc = 1'b1;
          w_state_nxt = enable ? S_ARM : S_IDLE;
        end
      end
      S_ARM: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (frame_end) begin
          vsync_irq    = 1'b1;
          w_issue_load = 1'b1;
          w_state_nxt  = S_ISSUE;
          if (swap_pending || swap_req) begin
            w_apply_swap = 1'b1;
            swap_done    = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (!enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Front buffer, swap request latch and command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      cmd_addr     <= '0;
      cmd_len      <= '0;
    end else begin
      front_sel <= w_front_nxt;
      if (w_apply_swap)  swap_pending <= 1'b0;
      else if (swap_req) swap_pending <= 1'b1;
      if (w_issue_load) begin
        cmd_addr <= w_front_nxt ? buf1_addr : buf0_addr;
        cmd_len  <= LEN_W'(FRAME_BYTES);
      end
    end
  end

  // Sticky status flags, cleared when the scheduler is re-enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      err      <= 1'b0;
    end else if (w_en_rise) begin
      underrun <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (w_underrun_ev) underrun <= 1'b1;
      if (w_err_ev)      err      <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_frame_inc),
    .clr    (w_en_rise),
    .sat_en (1'b0),
    .q      (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_underrun_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_underrun_ev),
    .clr    (w_en_rise),
    .sat_en (1'b1),
    .q      (underrun_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_frame_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_dma_sched
// Description : Self-checking bench for frame_dma_sched: directed frame,
//               swap, underrun, stall and error sequences followed by random
//               traffic, all compared against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_dma_sched;

  localparam int ADDR_W      = 32;
  localparam int LEN_W       = 23;
  localparam int CNT_W       = 16;
  localparam int FRAME_BYTES = 640 * 480 * 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] buf0_addr = '0;
  logic [ADDR_W-1:0] buf1_addr = '0;
  logic              swap_req = 1'b0;
  logic              frame_end = 1'b0;
  logic              cmd_ready = 1'b0;
  logic              dma_done = 1'b0;
  logic              dma_err = 1'b0;
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              front_sel;
  logic              swap_pending;
  logic              swap_done;
  logic              vsync_irq;
  logic              underrun;
  logic              err;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  underrun_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] d_b0, d_b1;

  // Reference model: what the scheduler is waiting on, plus visible status
  bit                m_fetch;    // command posted, not yet accepted
  bit                m_flight;   // frame transfer running
  bit                m_armed;    // waiting for the next frame boundary
  bit                m_fault;    // stopped on DMA error
  bit                m_front, m_swp, m_under, m_err, m_en_prev;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic [CNT_W-1:0]  m_fcnt, m_ucnt;

  frame_dma_sched #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .FRAME_BYTES (FRAME_BYTES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .buf0_addr    (buf0_addr),
    .buf1_addr    (buf1_addr),
    .swap_req     (swap_req),
    .frame_end    (frame_end),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .dma_done     (dma_done),
    .dma_err      (dma_err),
    .front_sel    (front_sel),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .vsync_irq    (vsync_irq),
    .underrun     (underrun),
    .err          (err),
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt)
  );

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs are compared with the model at negedge,
  // then the model consumes the same inputs the DUT sees at the next posedge.
  task automatic step(input bit en, input bit rdy, input bit fe,
                      input bit done, input bit derr, input bit swp);
    bit rise, und, apply, irq, idle, err_ev, done_ev;
    @(posedge clk);
    #1;
    enable    = en;
    cmd_ready = rdy;
    frame_end = fe;
    dma_done  = done;
    dma_err   = derr;
    swap_req  = swp;
    buf0_addr = d_b0;
    buf1_addr = d_b1;
    @(negedge clk);

    rise  = en && !m_en_prev;
    und   = fe && (m_fetch || m_flight);
    apply = m_armed && en && fe && (m_swp || swp);
    irq   = und || (m_armed && en && fe);

    check_val("cmd_valid",    64'(cmd_valid),    64'(m_fetch));
    check_val("cmd_addr",     64'(cmd_addr),     64'(m_addr));
    check_val("cmd_len",      64'(cmd_len),      64'(m_len));
    check_val("front_sel",    64'(front_sel),    64'(m_front));
    check_val("swap_pending", 64'(swap_pending), 64'(m_swp));
    check_val("swap_done",    64'(swap_done),    64'(apply));
    check_val("vsync_irq",    64'(vsync_irq),    64'(irq));
    check_val("underrun",     64'(underrun),     64'(m_under));
    check_val("err",          64'(err),          64'(m_err));
    check_val("frame_cnt",    64'(frame_cnt),    64'(m_fcnt));
    check_val("underrun_cnt", 64'(underrun_cnt), 64'(m_ucnt));

    err_ev  = 1'b0;
    done_ev = 1'b0;
    idle    = !(m_fetch || m_flight || m_armed || m_fault);
    if (idle) begin
      if (en) begin
        m_fetch = 1'b1;
        m_addr  = m_front ? d_b1 : d_b0;
        m_len   = LEN_W'(FRAME_BYTES);
      end
    end else if (m_fetch) begin
      if (rdy) begin
        m_fetch  = 1'b0;
        m_flight = 1'b1;
      end
    end else if (m_flight) begin
      if (derr) begin
        m_flight = 1'b0;
        m_fault  = 1'b1;
        err_ev   = 1'b1;
      end else if (done) begin
        m_flight = 1'b0;
        m_armed  = en;
        done_ev  = 1'b1;
      end
    end else if (m_armed) begin
      if (!en) begin
        m_armed = 1'b0;
      end else if (fe) begin
        m_armed = 1'b0;
        m_front = m_front ^ apply;
        m_fetch = 1'b1;
        m_addr  = m_front ? d_b1 : d_b0;
        m_len   = LEN_W'(FRAME_BYTES);
      end
    end else begin
      if (!en) m_fault = 1'b0;
    end

    if (apply)    m_swp = 1'b0;
    else if (swp) m_swp = 1'b1;

    if (rise) begin
      m_under = 1'b0;
      m_err   = 1'b0;
      m_fcnt  = '0;
      m_ucnt  = '0;
    end else begin
      if (und) begin
        m_under = 1'b1;
        if (m_ucnt != {CNT_W{1'b1}}) m_ucnt = m_ucnt + 1'b1;
      end
      if (err_ev)  m_err  = 1'b1;
      if (done_ev) m_fcnt = m_fcnt + 1'b1;
    end
    m_en_prev = en;
  endtask

  initial begin
    bit r_en;
    m_fetch = 0; m_flight = 0; m_armed = 0; m_fault = 0;
    m_front = 0; m_swp = 0; m_under = 0; m_err = 0; m_en_prev = 0;
    m_addr = '0; m_len = '0; m_fcnt = '0; m_ucnt = '0;
    d_b0 = 32'h8000_0000;
    d_b1 = 32'h8010_0000;

    // Reset: every output must be zero
    repeat (3) @(negedge clk);
    check_val("rst cmd_valid",    64'(cmd_valid),    64'd0);
    check_val("rst cmd_addr",     64'(cmd_addr),     64'd0);
    check_val("rst cmd_len",      64'(cmd_len),      64'd0);
    check_val("rst front_sel",    64'(front_sel),    64'd0);
    check_val("rst vsync_irq",    64'(vsync_irq),    64'd0);
    check_val("rst frame_cnt",    64'(frame_cnt),    64'd0);
    check_val("rst underrun_cnt", 64'(underrun_cnt), 64'd0);
    rst_n = 1'b1;

    // Priming fetch
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    check_val("prime valid", 64'(cmd_valid), 64'd1);
    check_val("prime addr",  64'(cmd_addr),  64'h8000_0000);
    check_val("prime len",   64'(cmd_len),   64'd921600);
    step(1,1,0,0,0,0);
    check_val("prime drop",  64'(cmd_valid), 64'd0);
    step(1,1,0,1,0,0);
    repeat (20) step(1,1,0,0,0,0);
    check_val("frame_cnt 1", 64'(frame_cnt), 64'd1);

    // Normal re-arm on frame_end
    step(1,1,1,0,0,0);
    check_val("rearm irq",   64'(vsync_irq), 64'd1);
    step(1,1,0,0,0,0);
    check_val("rearm valid", 64'(cmd_valid), 64'd1);
    check_val("rearm addr",  64'(cmd_addr),  64'h8000_0000);

    // Swap requested mid-transfer, applied at the next boundary
    step(1,1,0,0,0,1);
    step(1,1,0,0,0,0);
    check_val("swap pend", 64'(swap_pending), 64'd1);
    step(1,1,0,1,0,0);
    repeat (5) step(1,1,0,0,0,0);
    check_val("swap still pend", 64'(swap_pending), 64'd1);
    step(1,1,1,0,0,0);
    check_val("swap_done", 64'(swap_done), 64'd1);
    step(1,1,0,0,0,0);
    check_val("swap front", 64'(front_sel),    64'd1);
    check_val("swap addr",  64'(cmd_addr),     64'h8010_0000);
    check_val("swap clear", 64'(swap_pending), 64'd0);

    // Underrun: frame_end while still transferring
    step(1,1,1,0,0,0);
    check_val("underrun irq", 64'(vsync_irq), 64'd1);
    step(1,1,0,0,0,0);
    check_val("underrun flag", 64'(underrun),     64'd1);
    check_val("underrun cnt",  64'(underrun_cnt), 64'd1);
    check_val("no extra cmd",  64'(cmd_valid),    64'd0);
    step(1,1,0,1,0,0);
    step(1,0,0,0,0,0);
    step(1,0,1,0,0,0);
    step(1,0,0,0,0,0);
    check_val("post-underrun valid", 64'(cmd_valid), 64'd1);

    // Stalled command survives enable=0 until accepted
    repeat (4) step(1,0,0,0,0,0);
    repeat (3) step(0,0,0,0,0,0);
    check_val("stall valid", 64'(cmd_valid), 64'd1);
    check_val("stall addr",  64'(cmd_addr),  64'h8010_0000);
    step(0,1,0,0,0,0);
    step(0,1,0,0,0,0);
    check_val("stall accepted", 64'(cmd_valid), 64'd0);
    step(0,1,0,1,0,0);
    step(0,1,1,0,0,0);
    check_val("idle irq",   64'(vsync_irq), 64'd0);
    check_val("idle cnt 4", 64'(frame_cnt), 64'd4);

    // Re-enable clears status; then done+err together
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    check_val("reen underrun", 64'(underrun),     64'd0);
    check_val("reen ucnt",     64'(underrun_cnt), 64'd0);
    check_val("reen fcnt",     64'(frame_cnt),    64'd0);
    step(1,1,0,0,0,0);
    step(1,1,0,1,0,0);
    step(1,1,0,0,0,0);
    check_val("reen fcnt 1", 64'(frame_cnt), 64'd1);
    step(1,1,1,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,1,1,0);
    step(1,1,1,0,0,0);
    check_val("err flag",      64'(err),       64'd1);
    check_val("err fcnt held", 64'(frame_cnt), 64'd1);
    check_val("err no irq",    64'(vsync_irq), 64'd0);
    check_val("err no cmd",    64'(cmd_valid), 64'd0);
    step(0,1,0,0,0,0);
    step(0,1,0,0,0,0);
    check_val("err sticky", 64'(err), 64'd1);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    check_val("err cleared",  64'(err),       64'd0);
    check_val("err fcnt clr", 64'(frame_cnt), 64'd0);
    check_val("reprime",      64'(cmd_valid), 64'd1);

    // Random traffic
    r_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) r_en = ~r_en;
      d_b0 = $urandom;
      d_b1 = $urandom;
      step(r_en,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
